// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and constants for the seven-segment scan driver
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = 2;

    typedef logic [6:0] seg_pattern_t;

    localparam seg_pattern_t SEG_OFF  = 7'h7F;
    localparam seg_pattern_t SEG_ZERO = 7'b1000000;

    typedef enum logic {GUARD, ON} slot_state_t;

    typedef enum logic {VISIBLE, HIDDEN} blink_phase_t;

endpackage

// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - pattern input and display drive bundle of the scan driver
interface seg_scan_driver_if;
    import seg_pkg::*;

    seg_pattern_t digit_segs [NUM_DIGITS-1:0];
    logic         load;
    logic         overflow;
    logic [3:0]   an;
    seg_pattern_t seg;
    logic         frame_done;

    modport master (
        output digit_segs, load, overflow,
        input  an, seg, frame_done
    );

    modport slave (
        input  digit_segs, load, overflow,
        output an, seg, frame_done
    );

endinterface

// File: rtl/seg_slot_timer.sv
// rtl/seg_slot_timer.sv - per-digit slot timing (guard/on) and digit index sequencing
module seg_slot_timer
    import seg_pkg::*;
#(
    parameter int DIGIT_TICKS = 100000,
    parameter int GUARD_TICKS = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             guard_active,
    output logic [IDX_W-1:0] digit_idx,
    output logic             frame_end
);

    localparam int CW = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(DIGIT_TICKS - 1);
    localparam logic [CW-1:0] GUARD_LAST = (GUARD_TICKS == 0) ? '0 : CW'(GUARD_TICKS - 1);
    // With no guard interval every slot opens directly in ON.
    localparam slot_state_t SLOT_START = (GUARD_TICKS == 0) ? ON : GUARD;

    slot_state_t      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Slot state, cycle-in-slot counter and digit index registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SLOT_START;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Next slot position: wrap the counter and move to the next digit at slot end.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (cnt_q == SLOT_LAST) begin
            cnt_d   = '0;
            idx_d   = idx_q + IDX_W'(1);
            state_d = SLOT_START;
        end else begin
            cnt_d = cnt_q + CW'(1);
            if (state_q == GUARD && cnt_q == GUARD_LAST) begin
                state_d = ON;
            end
        end
    end

    assign guard_active = (state_q == GUARD);
    assign digit_idx    = idx_q;
    assign frame_end    = (idx_q == IDX_W'(NUM_DIGITS - 1)) && (cnt_q == SLOT_LAST);

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 4-digit multiplexed display scan with frame-synchronous load and overflow blink; SEG_LZB_EN adds leading-zero blanking
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGIT_TICKS  = 100000,
    parameter int GUARD_TICKS  = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_scan_driver_if.slave bus
);

    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    // The timer runs one cycle ahead of the pins; the output registers
    // below turn its current position into what is shown next cycle.
    logic             guard_active;
    logic [IDX_W-1:0] digit_idx;
    logic             frame_end;

    seg_pattern_t     shadow_q [NUM_DIGITS-1:0];
    seg_pattern_t     shadow_d [NUM_DIGITS-1:0];
    logic             ovf_q, ovf_d;
    logic             load_pending_q, load_pending_d;
    blink_phase_t     phase_q, phase_d;
    logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
    logic [NUM_DIGITS-1:0] blank_vis;
    logic             capture;

    logic [3:0]       an_q, an_d;
    seg_pattern_t     seg_q, seg_d;
    logic             frame_done_q;

    seg_slot_timer #(
        .DIGIT_TICKS (DIGIT_TICKS),
        .GUARD_TICKS (GUARD_TICKS)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .guard_active (guard_active),
        .digit_idx    (digit_idx),
        .frame_end    (frame_end)
    );

    // Frame boundary: capture, pending-load bookkeeping and blink phase stepping.
    always_comb begin
        capture        = frame_done_q && (load_pending_q || bus.load);
        shadow_d       = shadow_q;
        ovf_d          = ovf_q;
        load_pending_d = load_pending_q;
        phase_d        = phase_q;
        blink_cnt_d    = blink_cnt_q;
        if (frame_done_q) begin
            load_pending_d = 1'b0;
        end else if (bus.load) begin
            load_pending_d = 1'b1;
        end
        if (capture) begin
            shadow_d = bus.digit_segs;
            ovf_d    = bus.overflow;
        end
        if (frame_done_q) begin
            if (capture && !bus.overflow) begin
                phase_d     = VISIBLE;
                blink_cnt_d = '0;
            end else if (ovf_q) begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d = '0;
                    phase_d     = (phase_q == VISIBLE) ? HIDDEN : VISIBLE;
                end else begin
                    blink_cnt_d = blink_cnt_q + BW'(1);
                end
            end
        end
    end

`ifdef SEG_LZB_EN
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    logic                  zero3, zero2, zero1;

    assign zero3 = (bus.digit_segs[3] == SEG_ZERO);
    assign zero2 = (bus.digit_segs[2] == SEG_ZERO);
    assign zero1 = (bus.digit_segs[1] == SEG_ZERO);

    // Leading-zero mask is fixed at capture so it always matches the shadow.
    always_comb begin
        blank_d = blank_q;
        if (capture) begin
            blank_d = {zero3, zero3 & zero2, zero3 & zero2 & zero1, 1'b0};
        end
    end

    // Stored leading-zero mask.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank_vis = blank_d;
`else
    assign blank_vis = '0;
`endif

    // Shadow patterns, load/overflow state and blink counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= SEG_OFF;
            end
            ovf_q          <= 1'b0;
            load_pending_q <= 1'b0;
            phase_q        <= VISIBLE;
            blink_cnt_q    <= '0;
        end else begin
            shadow_q       <= shadow_d;
            ovf_q          <= ovf_d;
            load_pending_q <= load_pending_d;
            phase_q        <= phase_d;
            blink_cnt_q    <= blink_cnt_d;
        end
    end

    // Next pin values use post-capture state so a new frame starts with the new data.
    always_comb begin
        an_d  = 4'b1111;
        seg_d = SEG_OFF;
        if (!guard_active && phase_d == VISIBLE && !blank_vis[digit_idx]) begin
            an_d  = ~(4'b0001 << digit_idx);
            seg_d = shadow_d[digit_idx];
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_q         <= 4'b1111;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_end;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

    localparam logic [27:0] P_BLANK = {4{7'h7F}};
    localparam logic [27:0] P_2345  = {7'h24, 7'h30, 7'h19, 7'h12};
    localparam logic [27:0] P_6789  = {7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [27:0] P_0042  = {7'h40, 7'h40, 7'h19, 7'h24};
    localparam logic [27:0] P_0000  = {4{7'h40}};
`ifdef SEG_LZB_EN
    localparam logic [3:0] LIT_0042 = 4'b0011;
    localparam logic [3:0] LIT_0000 = 4'b0001;
`else
    localparam logic [3:0] LIT_0042 = 4'b1111;
    localparam logic [3:0] LIT_0000 = 4'b1111;
`endif

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    int   n_fail;
    int   frame_no;

    seg_scan_driver_if bus();

    seg_scan_driver #(
        .DIGIT_TICKS  (8),
        .GUARD_TICKS  (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_segs(input logic [27:0] pats);
        for (int i = 0; i < 4; i++) begin
            bus.digit_segs[i] = pats[i*7 +: 7];
        end
    endtask

    // Checks ncyc cycles of one frame, starting at slot position 0.
    // At position ld_at new patterns are driven, with a load pulse when ld_en.
    task automatic run_frame(input logic [27:0] exp_pats, input logic [3:0] exp_lit,
                             input int ld_at, input logic [27:0] ld_pats,
                             input logic ld_ovf, input logic ld_en, input int ncyc);
        for (int p = 0; p < ncyc; p++) begin
            int d;
            int sub;
            logic on;
            logic [3:0] exp_an;
            @(negedge clk);
            d      = p / 8;
            sub    = p % 8;
            on     = (sub >= 2) && exp_lit[d];
            exp_an = on ? ~(4'b0001 << d) : 4'b1111;
            chk($sformatf("an f%0d p%0d", frame_no, p), 7'(bus.an), 7'(exp_an));
            if (on) begin
                chk($sformatf("seg f%0d p%0d", frame_no, p), bus.seg, exp_pats[d*7 +: 7]);
            end
            chk($sformatf("frame_done f%0d p%0d", frame_no, p), 7'(bus.frame_done), 7'(p == 31));
            bus.load = 1'b0;
            if (p == ld_at) begin
                set_segs(ld_pats);
                if (ld_en) begin
                    bus.overflow = ld_ovf;
                    bus.load     = 1'b1;
                end
            end
        end
        frame_no++;
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        n_fail   = 0;
        frame_no = 1;
        rst_n        = 1'b0;
        bus.load     = 1'b0;
        bus.overflow = 1'b0;
        set_segs(P_BLANK);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset an", 7'(bus.an), 7'h0F);
        chk("reset seg", bus.seg, 7'h7F);
        chk("reset frame_done", 7'(bus.frame_done), 7'h00);
        rst_n = 1'b1;

        // empty shadow, then mid-frame load of 2345
        run_frame(P_BLANK, 4'b1111, -1, P_BLANK, 1'b0, 1'b0, 32);
        run_frame(P_BLANK, 4'b1111, 10, P_2345, 1'b0, 1'b1, 32);
        // load in the boundary cycle, then new inputs without a load
        run_frame(P_2345, 4'b1111, 31, P_6789, 1'b0, 1'b1, 32);
        run_frame(P_6789, 4'b1111, 5, P_0042, 1'b0, 1'b0, 32);
        // leading zeros
        run_frame(P_6789, 4'b1111, 12, P_0042, 1'b0, 1'b1, 32);
        run_frame(P_0042, LIT_0042, 20, P_0000, 1'b0, 1'b1, 32);
        // overflow blink
        run_frame(P_0000, LIT_0000, 3, P_6789, 1'b1, 1'b1, 32);
        run_frame(P_6789, 4'b1111, -1, P_BLANK, 1'b0, 1'b0, 32);
        run_frame(P_6789, 4'b1111, -1, P_BLANK, 1'b0, 1'b0, 32);
        run_frame(P_6789, 4'b0000, 7, P_2345, 1'b0, 1'b1, 32);
        run_frame(P_2345, 4'b1111, 9, P_6789, 1'b1, 1'b1, 32);
        run_frame(P_6789, 4'b1111, -1, P_BLANK, 1'b0, 1'b0, 32);
        run_frame(P_6789, 4'b1111, -1, P_BLANK, 1'b0, 1'b0, 32);
        run_frame(P_6789, 4'b0000, -1, P_BLANK, 1'b0, 1'b0, 32);
        // reset during digit 2 ON with a load pending
        run_frame(P_6789, 4'b0000, 4, P_2345, 1'b0, 1'b1, 20);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset an", 7'(bus.an), 7'h0F);
        chk("midreset seg", bus.seg, 7'h7F);
        chk("midreset frame_done", 7'(bus.frame_done), 7'h00);
        rst_n = 1'b1;
        run_frame(P_BLANK, 4'b1111, -1, P_BLANK, 1'b0, 1'b0, 32);
        run_frame(P_BLANK, 4'b1111, -1, P_BLANK, 1'b0, 1'b0, 32);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed scan driver for the 4-digit common-anode seven-segment display. It sits directly downstream of the four per-digit segment decoders and takes their four 7-bit active-low patterns. It snapshots those patterns at frame boundaries so the display never tears, then drives one anode at a time with a ghost-suppression guard interval. It also supports blinking the display on calculator overflow.

## Interface
- `DIGIT_TICKS`, default 100000: clock cycles per digit slot (1 ms at 100 MHz). Must be ≥ 2.
- `GUARD_TICKS`, default 1000: cycles at the start of each slot with all anodes off. Legal range 0..DIGIT_TICKS-1.
- `BLINK_FRAMES`, default 125: frames per blink half-period. Must be ≥ 1.
- `clk` in 1: system clock. Single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `digit_segs` in 4×7: unpacked `[3:0]` array. Index 0 is the rightmost (ones) digit. Each entry is active-low segments, bit6..0 = g..a.
- `load` in 1: one-cycle request to capture `digit_segs` and `overflow` at the next frame boundary.
- `overflow` in 1: result out of range; sampled together with `digit_segs`.
- `an` out 4: anode enables, active-low, `an[i]` drives digit i.
- `seg` out 7: segment drive, active-low, g..a.
- `frame_done` out 1: one-cycle pulse on the last cycle of each frame.

## Operation
- **Reset values:** `an`=4'b1111, `seg`=7'h7F, `frame_done`=0. Shadow patterns are all 7'h7F, `load_pending`=0, `ovf_q`=0. Digit index is 0, state is GUARD, slot counter 0, blink counter 0, blink phase VISIBLE.
- **Slot FSM, per digit:**
  - GUARD lasts GUARD_TICKS cycles, with `an`=1111 and `seg`=7F.
  - ON lasts DIGIT_TICKS−GUARD_TICKS cycles, with `an` one-cold at the current index and `seg` = shadow[index].
  - If GUARD_TICKS=0, the GUARD state is skipped entirely.
- **Index sequence:** the digit index advances 0→1→2→3→0 at the end of each slot. A frame is 4·DIGIT_TICKS cycles.
- **Load handling:**
  - A `load` pulse sets `load_pending`.
  - At the frame boundary (last cycle of digit 3), if `load_pending` is set or `load` is high in that same cycle, the shadow registers and `ovf_q` capture the current `digit_segs`/`overflow`, and `load_pending` clears.
  - A `load` in the boundary cycle is consumed there. It does not leave `load_pending` set.
  - Multiple loads within one frame collapse into one; the capture uses the inputs at the boundary.
- **Blink:**
  - While `ovf_q`=1, the blink counter counts frames and the phase toggles every BLINK_FRAMES frames.
  - During the HIDDEN phase, `an`=1111 in both GUARD and ON. Timing continues unchanged.
  - When a capture sets `ovf_q`=0, the phase forces to VISIBLE and the counter clears.
- A digit whose shadow pattern is 7F is still scanned, with its anode low and all segments dark.

## Timing
- All outputs are registered. No combinational path exists from inputs to outputs.
- **Capture-to-display latency:** the new shadow is visible from the first ON cycle of digit 0 in the next frame. Worst case from a `load` pulse is 4·DIGIT_TICKS+GUARD_TICKS+1 cycles.
- `frame_done` is high exactly in the capture cycle, once per frame.
- **After reset release:** the first slot starts in the next cycle (digit 0, GUARD).
- **Reset asserted mid-slot:** on the next edge, all state returns to its reset values. Pending loads are discarded.

## Configuration
- `SEG_LZB_EN` defined (leading-zero blanking):
  - Digits 3..1 are suppressed when their shadow equals SEG_ZERO (7'b1000000) and every higher digit is also suppressed. A suppressed digit keeps `an[i]`=1 for its whole slot, but slot timing is unchanged.
  - Digit 0 is never suppressed.
  - The suppression mask is computed at capture and stored with the shadow.
- `SEG_LZB_EN` undefined: all four digits are always displayed and no mask logic exists.

## Structure
- **Package `seg_pkg`:**
  - `NUM_DIGITS`=4.
  - `SEG_OFF`=7'h7F and `SEG_ZERO`=7'b1000000.
  - `typedef enum {GUARD, ON} slot_state_t`.
  - `typedef logic [6:0] seg_pattern_t`.
- **Sub-module `seg_slot_timer`:** slot counter and digit index. It outputs `guard_active`, `digit_idx`, and `frame_end`. The parent holds the shadow registers, load/blink logic and output registers.

## Test plan
Bench parameters: DIGIT_TICKS=8, GUARD_TICKS=2, BLINK_FRAMES=2.
1. **Reset:** hold `rst_n` low 3 cycles → `an`=1111, `seg`=7F, `frame_done`=0. After release, 2 GUARD cycles, then `an`=1110 with `seg`=7F (empty shadow).
2. **Mid-frame load:** load "2345" (d3..d0 = 0100100, 0110000, 0011001, 0010010) at cycle 10 → display unchanged until `frame_done`. Next frame shows `an`=1110 `seg`=0010010, …, `an`=0111 `seg`=0100100.
3. **Load in boundary cycle:** `load` with "6789" in the `frame_done` cycle → visible in the immediately following frame, and no second capture occurs.
4. **Leading zeros:** load "0042". With `SEG_LZB_EN`, `an[3]` and `an[2]` never go low. Without it, all four anodes cycle. Load "0000" with `SEG_LZB_EN` → only `an[0]` is ever low.
5. **Overflow blink:** load with `overflow`=1 → 2 frames visible, then 2 frames with `an`=1111, repeating. A load with `overflow`=0 → visible from the next frame, and the counter clears.
6. **Reset mid-operation:** assert `rst_n`=0 during the digit 2 ON phase with a load pending → next cycle shows reset outputs. After release, the pending load is not applied and `seg`=7F.
